// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier request arbiter.
// The WAIT-state watchdog is enabled by defining MULT_ARB_TIMEOUT_EN.
package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 64;

   // Index width for n requesters; never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_req_arbiter_rr.sv
// Combinational round-robin priority encoder: the lowest requesting index
// at or above ptr (wrapping modulo N) wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW:0]   sum_s;
   logic [IW-1:0] idx_s;
   logic [IW-1:0] win_s;

   // Scan from the farthest offset down so the nearest requester overwrites last.
   always_comb begin
      sum_s = '0;
      idx_s = '0;
      win_s = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum_s = {1'b0, ptr} + (IW+1)'(k);
         idx_s = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : IW'(sum_s);
         win_s = req[idx_s] ? idx_s : win_s;
      end
      any          = |req;
      grant_idx    = win_s;
      grant_onehot = any ? (N'(1) << win_s) : '0;
   end

endmodule

// File: rtl/mult_req_arbiter.sv
// Round-robin sharing of one multi-cycle multiplier core among NUM_REQ requesters.
// Optional WAIT watchdog: define MULT_ARB_TIMEOUT_EN.
module mult_req_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]   req_a,
   input  logic [NUM_REQ*DATA_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]          rsp_valid,
   input  logic [NUM_REQ-1:0]          rsp_ready,
   output logic [2*DATA_W-1:0]         rsp_product,
   output logic                        rsp_err,
   output logic                        mult_start,
   output logic [DATA_W-1:0]           mult_a,
   output logic [DATA_W-1:0]           mult_b,
   input  logic                        mult_done,
   input  logic [2*DATA_W-1:0]         mult_product,
   output logic                        busy,
   output logic [grant_w(NUM_REQ)-1:0] grant_id
);

   localparam int GW = grant_w(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("mult_req_arbiter: unsupported parameter values");
   end

   state_t                state_r;
   logic [GW-1:0]         ptr_r;
   logic [GW-1:0]         grant_id_r;
   logic [GW-1:0]         grant_idx_s;
   logic [GW-1:0]         ptr_next_s;
   logic [NUM_REQ-1:0]    grant_onehot_s;
   logic [NUM_REQ-1:0]    rsp_valid_r;
   logic                  any_s;
   logic                  accept_s;
   logic                  handshake_s;
   logic                  mult_start_r;
   logic                  busy_r;
   logic [DATA_W-1:0]     mult_a_r;
   logic [DATA_W-1:0]     mult_b_r;
   logic [DATA_W-1:0]     sel_a_s;
   logic [DATA_W-1:0]     sel_b_s;
   logic [2*DATA_W-1:0]   rsp_product_r;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (GW)
   ) u_rr (
      .req          (req_valid),
      .ptr          (ptr_r),
      .grant_onehot (grant_onehot_s),
      .grant_idx    (grant_idx_s),
      .any          (any_s)
   );

   // Accept/handshake decode and the winner's operand slices.
   always_comb begin
      req_ready   = (state_r == IDLE) ? grant_onehot_s : '0;
      accept_s    = (state_r == IDLE) && any_s;
      handshake_s = (state_r == RESP) && rsp_ready[grant_id_r];
      ptr_next_s  = (grant_idx_s == GW'(NUM_REQ - 1)) ? '0 : grant_idx_s + GW'(1);
      sel_a_s     = req_a[int'(grant_idx_s) * DATA_W +: DATA_W];
      sel_b_s     = req_b[int'(grant_idx_s) * DATA_W +: DATA_W];
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] to_cnt_r;
   logic          rsp_err_r;
   logic          timeout_s;

   // Counter value TIMEOUT_CYC-1 marks the last allowed WAIT cycle.
   always_comb begin
      timeout_s = (to_cnt_r == CW'(TIMEOUT_CYC - 1));
   end
`endif

   // Operation FSM; every register here returns to its reset value on ARESETN low.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_r       <= IDLE;
         ptr_r         <= '0;
         grant_id_r    <= '0;
         mult_start_r  <= 1'b0;
         mult_a_r      <= '0;
         mult_b_r      <= '0;
         rsp_valid_r   <= '0;
         rsp_product_r <= '0;
         busy_r        <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
         to_cnt_r      <= '0;
         rsp_err_r     <= 1'b0;
`endif
      end else begin
         mult_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r      <= ISSUE;
                  grant_id_r   <= grant_idx_s;
                  ptr_r        <= ptr_next_s;
                  mult_a_r     <= sel_a_s;
                  mult_b_r     <= sel_b_s;
                  mult_start_r <= 1'b1;
                  busy_r       <= 1'b1;
               end
            end
            ISSUE: begin
               state_r <= WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
               to_cnt_r <= '0;
`endif
            end
            WAIT: begin
               // A done coinciding with the timeout takes precedence.
               if (mult_done) begin
                  state_r       <= RESP;
                  rsp_valid_r   <= NUM_REQ'(1) << grant_id_r;
                  rsp_product_r <= mult_product;
`ifdef MULT_ARB_TIMEOUT_EN
                  rsp_err_r     <= 1'b0;
               end else if (timeout_s) begin
                  state_r       <= RESP;
                  rsp_valid_r   <= NUM_REQ'(1) << grant_id_r;
                  rsp_product_r <= '0;
                  rsp_err_r     <= 1'b1;
               end else begin
                  to_cnt_r <= to_cnt_r + CW'(1);
`endif
               end
            end
            RESP: begin
               if (handshake_s) begin
                  state_r     <= IDLE;
                  rsp_valid_r <= '0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid   = rsp_valid_r;
   assign rsp_product = rsp_product_r;
   assign mult_start  = mult_start_r;
   assign mult_a      = mult_a_r;
   assign mult_b      = mult_b_r;
   assign busy        = busy_r;
   assign grant_id    = grant_id_r;
`ifdef MULT_ARB_TIMEOUT_EN
   assign rsp_err     = rsp_err_r;
`else
   assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_req_arbiter.sv
// Directed self-checking bench for mult_req_arbiter with a behavioural multiplier core.
// The watchdog sequence is compiled in only when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_req_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int TO  = 64;
   localparam int LAT = 3;

   logic              ACLK    = 1'b0;
   logic              ARESETN = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a = '0;
   logic [NR*DW-1:0]  req_b = '0;
   logic [NR-1:0]     rsp_valid;
   logic [NR-1:0]     rsp_ready = '0;
   logic [2*DW-1:0]   rsp_product;
   logic              rsp_err;
   logic              mult_start;
   logic [DW-1:0]     mult_a;
   logic [DW-1:0]     mult_b;
   logic              mult_done;
   logic [2*DW-1:0]   mult_product;
   logic              busy;
   logic [1:0]        grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   bit          core_mute  = 1'b0;
   bit          stray_done = 1'b0;
   int          core_cnt;
   logic [63:0] core_prod;

   typedef struct {
      int          idx;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[6];

   mult_req_arbiter #(
      .NUM_REQ     (NR),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_product  (rsp_product),
      .rsp_err      (rsp_err),
      .mult_start   (mult_start),
      .mult_a       (mult_a),
      .mult_b       (mult_b),
      .mult_done    (mult_done),
      .mult_product (mult_product),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   always #5 ACLK = ~ACLK;

   // Multiplier core: done pulse LAT+1 edges after start; stray_done injects a spurious pulse.
   always @(posedge ACLK) begin
      if (!ARESETN) begin
         core_cnt     <= 0;
         mult_done    <= 1'b0;
         mult_product <= '0;
      end else if (stray_done) begin
         mult_done    <= 1'b1;
         mult_product <= 64'hDEAD_BEEF_0BAD_F00D;
      end else if (mult_start) begin
         core_cnt  <= LAT;
         core_prod <= 64'(mult_a) * 64'(mult_b);
         mult_done <= 1'b0;
      end else if (core_cnt == 1) begin
         core_cnt     <= 0;
         mult_done    <= !core_mute;
         mult_product <= core_prod;
      end else begin
         if (core_cnt > 0) core_cnt <= core_cnt - 1;
         mult_done <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input string name);
      bit ok = 1'b0;
      req_valid[idx] = 1'b1;
      req_a[idx*DW +: DW] = a;
      req_b[idx*DW +: DW] = b;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (req_ready[idx]) begin
            ok = 1'b1;
            break;
         end
         @(negedge ACLK);
      end
      chk({name, " accept"}, 64'(ok), 64'd1);
      @(negedge ACLK);
      req_valid[idx] = 1'b0;
      req_a[idx*DW +: DW] = ~a;
      req_b[idx*DW +: DW] = ~b;
      chk({name, " start"}, 64'(mult_start), 64'd1);
      chk({name, " grant_id"}, 64'(grant_id), 64'(idx));
      chk({name, " mult_a"}, 64'(mult_a), 64'(a));
      chk({name, " mult_b"}, 64'(mult_b), 64'(b));
      chk({name, " busy"}, 64'(busy), 64'd1);
      @(negedge ACLK);
      chk({name, " start pulse"}, 64'(mult_start), 64'd0);
      chk({name, " mult_a hold"}, 64'(mult_a), 64'(a));
   endtask

   task automatic wait_rsp(input int idx, input logic [63:0] exp, input logic exp_err,
                           input string name);
      bit ok = 1'b0;
      logic [NR-1:0] oh;
      oh = 4'b0001 << idx;
      for (int c = 0; c < 200; c++) begin
         if (rsp_valid != '0) begin
            ok = 1'b1;
            break;
         end
         @(negedge ACLK);
      end
      chk({name, " rsp seen"}, 64'(ok), 64'd1);
      chk({name, " rsp_valid"}, 64'(rsp_valid), 64'(oh));
      chk({name, " rsp grant_id"}, 64'(grant_id), 64'(idx));
      chk({name, " product"}, rsp_product, exp);
      chk({name, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
      rsp_ready[idx] = 1'b1;
      @(negedge ACLK);
      rsp_ready[idx] = 1'b0;
      chk({name, " rsp drop"}, 64'(rsp_valid), 64'd0);
      chk({name, " idle"}, 64'(busy), 64'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          k;
      int          gorder[5];
      logic [63:0] p4[4];

      vecs[0] = '{idx: 1, a: 32'd3,          b: 32'd7,          p: 64'h0000_0000_0000_0015};
      vecs[1] = '{idx: 0, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{idx: 2, a: 32'h0001_0000,  b: 32'h0001_0000,  p: 64'h0000_0001_0000_0000};
      vecs[3] = '{idx: 3, a: 32'd0,          b: 32'h1234_5678,  p: 64'h0000_0000_0000_0000};
      vecs[4] = '{idx: 1, a: 32'h8000_0000,  b: 32'd2,          p: 64'h0000_0001_0000_0000};
      vecs[5] = '{idx: 3, a: 32'h1234_5678,  b: 32'h0000_0010,  p: 64'h0000_0001_2345_6780};
      gorder = '{0, 1, 2, 3, 0};
      p4     = '{64'd20, 64'd60, 64'd120, 64'd200};

      // Reset values
      repeat (3) @(negedge ACLK);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset start", 64'(mult_start), 64'd0);
      chk("reset mult_a", 64'(mult_a), 64'd0);
      chk("reset mult_b", 64'(mult_b), 64'd0);
      chk("reset grant_id", 64'(grant_id), 64'd0);
      chk("reset product", rsp_product, 64'd0);
      chk("reset err", 64'(rsp_err), 64'd0);
      ARESETN = 1'b1;
      @(negedge ACLK);

      // Single-requester table
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].idx, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
         wait_rsp(vecs[i].idx, vecs[i].p, 1'b0, $sformatf("vec%0d", i));
      end

      // Reset during WAIT
      issue(2, 32'd5, 32'd6, "midrst");
      ARESETN = 1'b0;
      @(negedge ACLK);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst start", 64'(mult_start), 64'd0);
      chk("midrst mult_a", 64'(mult_a), 64'd0);
      chk("midrst mult_b", 64'(mult_b), 64'd0);
      chk("midrst grant_id", 64'(grant_id), 64'd0);
      chk("midrst product", rsp_product, 64'd0);
      ARESETN = 1'b1;
      repeat (8) @(negedge ACLK);
      chk("midrst no stale rsp", 64'(rsp_valid), 64'd0);

      // Spurious done while idle
      stray_done = 1'b1;
      @(negedge ACLK);
      stray_done = 1'b0;
      @(negedge ACLK);
      chk("idle done busy", 64'(busy), 64'd0);
      chk("idle done rsp_valid", 64'(rsp_valid), 64'd0);

      // All requesters valid continuously: grants 0,1,2,3,0 (ptr reset to 0)
      for (int i = 0; i < NR; i++) begin
         req_a[i*DW +: DW] = 32'(i + 2);
         req_b[i*DW +: DW] = 32'(10 * (i + 1));
      end
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_rsp(gorder[g], p4[gorder[g]], 1'b0, $sformatf("rr%0d", g));
      end
      req_valid = 4'b0000;

      // RESP stall with competing request; ptr=1 so requester 1 wins over 3
      @(negedge ACLK);
      req_valid[1] = 1'b1; req_a[1*DW +: DW] = 32'd9; req_b[1*DW +: DW] = 32'd9;
      req_valid[3] = 1'b1; req_a[3*DW +: DW] = 32'd7; req_b[3*DW +: DW] = 32'd11;
      k = 0;
      while (rsp_valid == '0 && k < 200) begin
         @(negedge ACLK);
         k++;
      end
      req_valid[1] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         stray_done = (c == 3);
         chk($sformatf("stall%0d rsp_valid", c), 64'(rsp_valid), 64'b0010);
         chk($sformatf("stall%0d product", c), rsp_product, 64'd81);
         chk($sformatf("stall%0d busy", c), 64'(busy), 64'd1);
         chk($sformatf("stall%0d req_ready", c), 64'(req_ready), 64'd0);
         @(negedge ACLK);
      end
      stray_done = 1'b0;
      rsp_ready[3] = 1'b1;
      @(negedge ACLK);
      rsp_ready[3] = 1'b0;
      chk("stall other ready", 64'(rsp_valid), 64'b0010);
      wait_rsp(1, 64'd81, 1'b0, "stall");
      chk("stall next ready", 64'(req_ready), 64'b1000);
      @(negedge ACLK);
      req_valid[3] = 1'b0;
      wait_rsp(3, 64'd77, 1'b0, "stall next");

      // Wrap: after a grant to 2, ptr=3 stays through idle cycles, so 3 beats 0
      issue(2, 32'd4, 32'd4, "wrap pre");
      wait_rsp(2, 64'd16, 1'b0, "wrap pre");
      repeat (5) @(negedge ACLK);
      req_valid[0] = 1'b1; req_a[0*DW +: DW] = 32'd100; req_b[0*DW +: DW] = 32'd3;
      req_valid[3] = 1'b1; req_a[3*DW +: DW] = 32'd8;   req_b[3*DW +: DW] = 32'd8;
      wait_rsp(3, 64'd64, 1'b0, "wrap3");
      req_valid[3] = 1'b0;
      @(negedge ACLK);
      req_valid[0] = 1'b0;
      wait_rsp(0, 64'd300, 1'b0, "wrap0");

`ifdef MULT_ARB_TIMEOUT_EN
      // Core never answers: RESP after TO WAIT cycles with error and zero product
      core_mute = 1'b1;
      issue(0, 32'd2, 32'd3, "tmo");
      k = 0;
      while (rsp_valid == '0 && k < 300) begin
         @(negedge ACLK);
         k++;
      end
      chk("tmo wait cycles", 64'(k), 64'(TO));
      chk("tmo rsp_valid", 64'(rsp_valid), 64'b0001);
      chk("tmo err", 64'(rsp_err), 64'd1);
      chk("tmo product", rsp_product, 64'd0);
      stray_done = 1'b1;
      @(negedge ACLK);
      stray_done = 1'b0;
      @(negedge ACLK);
      chk("tmo late done err", 64'(rsp_err), 64'd1);
      chk("tmo late done product", rsp_product, 64'd0);
      rsp_ready[0] = 1'b1;
      @(negedge ACLK);
      rsp_ready[0] = 1'b0;
      chk("tmo rsp drop", 64'(rsp_valid), 64'd0);
      core_mute = 1'b0;
      issue(1, 32'd6, 32'd7, "tmo after");
      wait_rsp(1, 64'd42, 1'b0, "tmo after");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
